core_l1d_resp: RTL
==================

# core_l1d_resp

Data-side responder at the far end of the core's L1D request bus, answering the loads and stores issued by the memory stage. Cacheable accesses are served from a local single-cycle tightly-coupled data RAM. Non-cacheable accesses, marked by the NC bit of the request cop, are forwarded over a valid/ready external bus, and the block waits for the reply. Every accepted request returns exactly one response pulse carrying lane-0-aligned read data or an error flag.

## Interface
- TCM_AW, 10: word-address width of the local RAM (depth 2^TCM_AW words).
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- l1d_req_val  in  1  request valid.
- l1d_req_rdy  out  1  request accepted when val&rdy.
- l1d_req_cop  in  3  [0]=1 write / 0 read; [1]=1 non-cacheable (NC region); [2] ignored.
- l1d_req_size  in  3  3'b000 byte, 3'b001 half, 3'b010 word; others illegal.
- l1d_req_addr  in  32  byte address.
- l1d_req_wdata  in  32  store data, right-aligned (byte/half in low bits).
- l1d_resp_val  out  1  one-cycle response pulse.
- l1d_resp_err  out  1  valid with resp_val; illegal size or misalignment.
- l1d_resp_rdata  out  32  load data in low lanes, zero-extended; 0 for writes/errors.
- nc_req_val  out  1  external request valid.
- nc_req_rdy  in  1  external request accepted.
- nc_req_we  out  1  external write.
- nc_req_be  out  4  byte enables.
- nc_req_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- nc_req_wdata  out  32  store data replicated into lanes.
- nc_resp_val  in  1  external response (reads and writes).
- nc_resp_rdata  in  32  external read word.

## Operation
- FSM states: IDLE, NC_REQ, NC_WAIT. l1d_req_rdy = (state==IDLE).
- Check on acceptance: err if size>2, half with addr[0]=1, or word with addr[1:0]!=0. An error response gets no RAM or bus access, has resp_err=1 and rdata=0, and stays in IDLE.
- Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
- Write lanes: byte is {4{wdata[7:0]}}, half is {2{wdata[15:0]}}, word is wdata.
- Local path (cop[1]=0, legal): the RAM is indexed by addr[TCM_AW+1:2], and upper bits alias. A write updates only the enabled bytes. A read selects the lane by addr[1:0]/size and zero-extends it to bit 0. The block stays in IDLE, so back-to-back requests are accepted every cycle.
- NC path (cop[1]=1, legal):
  - IDLE→NC_REQ: the request is captured (we, be, addr, lane-replicated wdata, size, addr[1:0]).
  - NC_REQ: nc_req_val=1 with stable fields until nc_req_rdy; then →NC_WAIT.
  - NC_WAIT: on nc_resp_val, the read lane is extracted from nc_resp_rdata as on the local path; then →IDLE.
- nc_resp_val outside NC_WAIT is ignored. nc_req_rdy outside NC_REQ is ignored.
- cop[2] does not affect behaviour.

## Timing
- Reset (asynchronous): state=IDLE, l1d_resp_val=0, l1d_resp_err=0, l1d_resp_rdata=0, nc_req_val=0, nc_req_we=0, nc_req_be=0, nc_req_addr=0, nc_req_wdata=0. RAM contents are undefined.
- All l1d_resp_* outputs are registered.
- Local or error latency: the request is accepted in cycle T, and resp_val=1 in T+1.
- NC latency:
  - Accept in T; nc_req_val=1 from T+1.
  - nc_req_rdy seen in cycle R moves the FSM to NC_WAIT in R+1.
  - nc_resp_val seen in cycle W (W≥R+1) gives l1d_resp_val=1 in W+1, with the FSM in IDLE and rdy=1 in the same cycle W+1.
  - A new request may be accepted in W+1.
- nc_req_rdy may already be high in T+1, giving a minimum 3-cycle NC round trip (accept to resp_val).
- Local read in T followed by a write to the same word in T+1: the read returns the old data. Write in T followed by read in T+1 returns the new data.
- Reset asserted in NC_REQ or NC_WAIT aborts the access with no response. A late nc_resp_val after reset is ignored.
- resp_val is never high for two consecutive cycles per request. It is 0 in any cycle without a completion.

## Test plan
- Local word write 0xDEADBEEF to addr 0x100, then word read at 0x100: response T+1, rdata=0xDEADBEEF, err=0; rdy stays 1 across back-to-back requests.
- Byte write 0xAA to 0x103 over 0x11223344, then byte read 0x103 → 0x000000AA; word read 0x100 → 0xAA223344; half read 0x102 → 0x0000AA22.
- Half read at 0x101 and size 3'b011 → resp_val next cycle with err=1, rdata=0, no RAM change, nc_req_val never asserts.
- NC word read at 0x80000004 with nc_req_rdy delayed 2 cycles and nc_resp_rdata=0x12345678 after 3 more cycles:
  - nc_req_val held with be=4'b1111 and addr=0x80000004; rdy=0 throughout.
  - l1d_resp_val fires one cycle after nc_resp_val with rdata=0x12345678.
- NC half write 0xBEEF at 0x80000002: nc_req_we=1, be=4'b1100, wdata=0xBEEFBEEF. resp_val follows nc_resp_val by one cycle, and a local read accepted in that same cycle responds in the next cycle.
- Assert rst_n low during NC_WAIT, release, then pulse nc_resp_val: no l1d_resp_val, all outputs at reset values, the next local request is served normally.

Source files
------------

// File: rtl/core_l1d_resp.sv
// L1D request responder: cacheable accesses are served from a byte-laned local TCM,
// non-cacheable ones go out over a valid/ready bus and the reply is returned lane-0 aligned.
module core_l1d_resp #(
    parameter int TCM_AW = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        l1d_req_val,
    output logic        l1d_req_rdy,
    input  logic [2:0]  l1d_req_cop,
    input  logic [2:0]  l1d_req_size,
    input  logic [31:0] l1d_req_addr,
    input  logic [31:0] l1d_req_wdata,
    output logic        l1d_resp_val,
    output logic        l1d_resp_err,
    output logic [31:0] l1d_resp_rdata,
    output logic        nc_req_val,
    input  logic        nc_req_rdy,
    output logic        nc_req_we,
    output logic [3:0]  nc_req_be,
    output logic [31:0] nc_req_addr,
    output logic [31:0] nc_req_wdata,
    input  logic        nc_resp_val,
    input  logic [31:0] nc_resp_rdata
);
    typedef enum logic [1:0] {IDLE, NC_REQ, NC_WAIT} state_t;
    localparam int DEPTH = 1 << TCM_AW;

    state_t      state_q;
    logic [2:0]  size_q;
    logic [1:0]  off_q;
    logic        resp_val_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;
    logic        nc_val_q;
    logic        nc_we_q;
    logic [3:0]  nc_be_q;
    logic [31:0] nc_addr_q;
    logic [31:0] nc_wdata_q;

    logic              accept;
    logic              req_err;
    logic              tcm_we;
    logic [3:0]        req_be;
    logic [31:0]       req_lanes;
    logic [31:0]       tcm_rword;
    logic [TCM_AW-1:0] tcm_idx;
    logic              unused_cop;

    // Shift the addressed lane down to bit 0 and zero-extend to the access size.
    function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  size);
        logic [31:0] shifted;
        shifted = word >> {off, 3'b000};
        case (size)
            3'd0:    return {24'd0, shifted[7:0]};
            3'd1:    return {16'd0, shifted[15:0]};
            default: return shifted;
        endcase
    endfunction

    always_comb begin
        req_be    = 4'b1111;
        req_lanes = l1d_req_wdata;
        case (l1d_req_size)
            3'd0: begin
                req_be    = 4'b0001 << l1d_req_addr[1:0];
                req_lanes = {4{l1d_req_wdata[7:0]}};
            end
            3'd1: begin
                req_be    = 4'b0011 << l1d_req_addr[1:0];
                req_lanes = {2{l1d_req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign req_err = (l1d_req_size > 3'd2)
                  || (l1d_req_size == 3'd1 && l1d_req_addr[0])
                  || (l1d_req_size == 3'd2 && l1d_req_addr[1:0] != 2'b00);
    assign accept     = l1d_req_val && (state_q == IDLE);
    assign tcm_we     = accept && !req_err && !l1d_req_cop[1] && l1d_req_cop[0];
    assign tcm_idx    = l1d_req_addr[TCM_AW+1:2];
    assign unused_cop = l1d_req_cop[2];

    // One byte-wide array per lane so partial stores touch only their enabled bytes.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem_q [DEPTH];
        always_ff @(posedge clk) begin
            if (tcm_we && req_be[gi]) begin
                mem_q[tcm_idx] <= req_lanes[gi*8 +: 8];
            end
        end
        assign tcm_rword[gi*8 +: 8] = mem_q[tcm_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            size_q       <= 3'd0;
            off_q        <= 2'd0;
            resp_val_q   <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            nc_val_q     <= 1'b0;
            nc_we_q      <= 1'b0;
            nc_be_q      <= 4'd0;
            nc_addr_q    <= 32'd0;
            nc_wdata_q   <= 32'd0;
        end else begin
            resp_val_q   <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (req_err) begin
                            resp_val_q <= 1'b1;
                            resp_err_q <= 1'b1;
                        end else if (l1d_req_cop[1]) begin
                            state_q    <= NC_REQ;
                            nc_val_q   <= 1'b1;
                            nc_we_q    <= l1d_req_cop[0];
                            nc_be_q    <= req_be;
                            nc_addr_q  <= {l1d_req_addr[31:2], 2'b00};
                            nc_wdata_q <= req_lanes;
                            size_q     <= l1d_req_size;
                            off_q      <= l1d_req_addr[1:0];
                        end else begin
                            resp_val_q   <= 1'b1;
                            resp_rdata_q <= l1d_req_cop[0] ? 32'd0
                                          : extract_lane(tcm_rword, l1d_req_addr[1:0], l1d_req_size);
                        end
                    end
                end
                NC_REQ: begin
                    if (nc_req_rdy) begin
                        nc_val_q <= 1'b0;
                        state_q  <= NC_WAIT;
                    end
                end
                NC_WAIT: begin
                    if (nc_resp_val) begin
                        resp_val_q   <= 1'b1;
                        resp_rdata_q <= nc_we_q ? 32'd0 : extract_lane(nc_resp_rdata, off_q, size_q);
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign l1d_req_rdy    = (state_q == IDLE);
    assign l1d_resp_val   = resp_val_q;
    assign l1d_resp_err   = resp_err_q;
    assign l1d_resp_rdata = resp_rdata_q;
    assign nc_req_val     = nc_val_q;
    assign nc_req_we      = nc_we_q;
    assign nc_req_be      = nc_be_q;
    assign nc_req_addr    = nc_addr_q;
    assign nc_req_wdata   = nc_wdata_q;
endmodule
